// File: rtl/addsub_arbiter_pkg.sv
// Shared constants and types for the two-requester add/sub arbiter.
// Opcodes, requester id width and the result-slot state encoding live here.
package addsub_arbiter_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int ID_W = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request and result handshake bundle for addsub_arbiter.
// The master side drives requests and consumes results; the slave side is the arbiter.
interface addsub_arbiter_if
  import addsub_arbiter_pkg::*;
#(
  parameter int N = 4
);

  logic            req0_valid;
  logic            req0_ready;
  logic [N-1:0]    req0_x;
  logic [N-1:0]    req0_y;
  logic            req0_op;

  logic            req1_valid;
  logic            req1_ready;
  logic [N-1:0]    req1_x;
  logic [N-1:0]    req1_y;
  logic            req1_op;

  logic            res_valid;
  logic            res_ready;
  logic [N-1:0]    res_s;
  logic            res_cout;
  logic            res_ovf;
  logic [ID_W-1:0] res_id;

  modport master (
    output req0_valid, req0_x, req0_y, req0_op,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_op,
    input  req1_ready,
    input  res_valid, res_s, res_cout, res_ovf, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_op,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_op,
    output req1_ready,
    output res_valid, res_s, res_cout, res_ovf, res_id,
    input  res_ready
  );

endinterface

// File: rtl/addsub_arbiter_sub_nbits.sv
// N-bit two's complement add/subtract core: s = x + (y ^ {n{cin}}) + cin.
// Overflow is judged on the effective operands x and the conditionally inverted y.
module sub_nbits #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [n-1:0] y_eff;
  logic [n:0]   sum;

  assign y_eff = y ^ {n{cin}};
  assign sum   = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, cin};
  assign s     = sum[n-1:0];
  assign cout  = sum[n];
  assign ovf   = (x[n-1] == y_eff[n-1]) && (sum[n-1] != x[n-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one add/sub core between two requesters, with a
// single registered result slot (valid/ready) tagged by requester id.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_arbiter_if.slave    bus
);

  slot_state_e     state_reg, state_next;
  logic [ID_W-1:0] last_id_reg;
  logic [N-1:0]    res_s_reg;
  logic            res_cout_reg;
  logic            res_ovf_reg;
  logic [ID_W-1:0] res_id_reg;

  logic            slot_free;
  logic            any_valid;
  logic            grant;
  logic [ID_W-1:0] win_id;
  logic [N-1:0]    win_x;
  logic [N-1:0]    win_y;
  logic            win_op;

  logic [N-1:0]    core_s;
  logic            core_cout;
  logic            core_ovf;

  // Readies are forced low during reset even though the slot reads as empty.
  assign slot_free = (state_reg == SLOT_EMPTY) || bus.res_ready;
  assign any_valid = bus.req0_valid || bus.req1_valid;
  assign grant     = rst_n && slot_free && any_valid;

  always_comb begin
    win_id = '0;
    if (bus.req0_valid && bus.req1_valid) begin
      win_id = ~last_id_reg;
    end else if (bus.req1_valid) begin
      win_id = 1'b1;
    end
  end

  always_comb begin
    win_x  = bus.req0_x;
    win_y  = bus.req0_y;
    win_op = bus.req0_op;
    if (win_id == 1'b1) begin
      win_x  = bus.req1_x;
      win_y  = bus.req1_y;
      win_op = bus.req1_op;
    end
  end

  assign bus.req0_ready = grant && (win_id == 1'b0);
  assign bus.req1_ready = grant && (win_id == 1'b1);

  sub_nbits #(.n(N)) u_core (
    .x    (win_x),
    .y    (win_y),
    .cin  (win_op == OP_SUB),
    .s    (core_s),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (grant) state_next = SLOT_FULL;
      SLOT_FULL:  if (bus.res_ready && !grant) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result registers hold their value when the slot drains, only a grant reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_reg  <= 1'b1;
      res_s_reg    <= '0;
      res_cout_reg <= 1'b0;
      res_ovf_reg  <= 1'b0;
      res_id_reg   <= '0;
    end else if (grant) begin
      last_id_reg  <= win_id;
      res_s_reg    <= core_s;
      res_cout_reg <= core_cout;
      res_ovf_reg  <= core_ovf;
      res_id_reg   <= win_id;
    end
  end

  assign bus.res_valid = (state_reg == SLOT_FULL);
  assign bus.res_s     = res_s_reg;
  assign bus.res_cout  = res_cout_reg;
  assign bus.res_ovf   = res_ovf_reg;
  assign bus.res_id    = res_id_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenarios with literal
// expectations, then randomized traffic against an arithmetic reference model.
module tb_addsub_arbiter;

  localparam int N   = 4;
  localparam int MOD = 2 ** N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_arbiter_if #(.N(N)) bus ();

  addsub_arbiter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic         v0 = 0, v1 = 0, op0 = 0, op1 = 0, rdy = 0;
  logic [N-1:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;

  assign bus.req0_valid = v0;
  assign bus.req0_x     = x0;
  assign bus.req0_y     = y0;
  assign bus.req0_op    = op0;
  assign bus.req1_valid = v1;
  assign bus.req1_x     = x1;
  assign bus.req1_y     = y1;
  assign bus.req1_op    = op1;
  assign bus.res_ready  = rdy;

  int tests = 0;
  int fails = 0;

  // Reference model state: the result slot and the last granted requester.
  bit m_valid, m_cout, m_ovf, m_id, m_last;
  int m_s;
  bit acc0, acc1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_s = 0; m_cout = 0; m_ovf = 0; m_id = 0; m_last = 1;
  endtask

  function automatic int to_signed(int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_op(input int x, input int y, input bit op,
                          output int s, output bit c, output bit o);
    int r, sr;
    if (!op) begin
      r  = x + y;
      s  = r % MOD;
      c  = (r >= MOD);
      sr = to_signed(x) + to_signed(y);
    end else begin
      r  = x - y;
      s  = (r + MOD) % MOD;
      c  = (x >= y);
      sr = to_signed(x) - to_signed(y);
    end
    o = (sr < -(MOD / 2)) || (sr > MOD / 2 - 1);
  endtask

  function automatic int winner();
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit free, g0, g1;
    int w, s;
    bit c, o;
    @(negedge clk);
    w    = winner();
    free = rst_n && (!m_valid || rdy);
    g0   = free && (w == 0);
    g1   = free && (w == 1);
    chk("req0_ready", int'(bus.req0_ready), int'(g0));
    chk("req1_ready", int'(bus.req1_ready), int'(g1));
    chk("res_valid",  int'(bus.res_valid),  int'(m_valid));
    chk("res_s",      int'(bus.res_s),      m_s);
    chk("res_cout",   int'(bus.res_cout),   int'(m_cout));
    chk("res_ovf",    int'(bus.res_ovf),    int'(m_ovf));
    chk("res_id",     int'(bus.res_id),     int'(m_id));
    @(posedge clk);
    if (rst_n) begin
      if (g0 || g1) begin
        if (g0) model_op(int'(x0), int'(y0), op0, s, c, o);
        else    model_op(int'(x1), int'(y1), op1, s, c, o);
        m_valid = 1; m_s = s; m_cout = c; m_ovf = o; m_id = g1; m_last = g1;
        $display("[TB] t=%0t grant id=%0d -> s=%0d cout=%0d ovf=%0d", $time, int'(g1), s, c, o);
      end else if (rdy) begin
        m_valid = 0;
      end
    end
    acc0 = g0;
    acc1 = g1;
    #1;
  endtask

  int saved_s;

  initial begin
    model_reset();
    acc0 = 0; acc1 = 0;

    // Reset state: readies stay low even with both requesters valid.
    v0 = 1; v1 = 1; rdy = 1;
    repeat (2) cycle();
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_s", int'(bus.res_s), 0);
    chk("rst_readies", int'(bus.req0_ready | bus.req1_ready), 0);
    v0 = 0; v1 = 0;
    rst_n = 1;

    // Requester 0 alone, add with signed overflow.
    v0 = 1; x0 = 4'b0111; y0 = 4'b0001; op0 = 0;
    cycle();
    v0 = 0;
    chk("t1_valid", int'(bus.res_valid), 1);
    chk("t1_s", int'(bus.res_s), 4'b1000);
    chk("t1_cout", int'(bus.res_cout), 0);
    chk("t1_ovf", int'(bus.res_ovf), 1);
    chk("t1_id", int'(bus.res_id), 0);

    // Requester 1 alone, two subtracts.
    v1 = 1; x1 = 4'b0011; y1 = 4'b0101; op1 = 1;
    cycle();
    chk("t2a_s", int'(bus.res_s), 4'b1110);
    chk("t2a_cout", int'(bus.res_cout), 0);
    chk("t2a_ovf", int'(bus.res_ovf), 0);
    chk("t2a_id", int'(bus.res_id), 1);
    x1 = 4'b1000; y1 = 4'b0001;
    cycle();
    chk("t2b_s", int'(bus.res_s), 4'b0111);
    chk("t2b_cout", int'(bus.res_cout), 1);
    chk("t2b_ovf", int'(bus.res_ovf), 1);
    v1 = 0;

    // Both valid continuously: grants alternate starting with requester 0.
    v0 = 1; x0 = 4'd1; y0 = 4'd2; op0 = 0;
    v1 = 1; x1 = 4'd5; y1 = 4'd1; op1 = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_id", int'(bus.res_id), i % 2);
      chk("t3_s", int'(bus.res_s), (i % 2) ? 4 : 3);
    end

    // Back-pressure: slot held, no grants.
    rdy = 0;
    saved_s = int'(bus.res_s);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_hold_valid", int'(bus.res_valid), 1);
      chk("t4_hold_s", int'(bus.res_s), saved_s);
      chk("t4_readies", int'(bus.req0_ready | bus.req1_ready), 0);
    end
    rdy = 1;
    cycle();
    chk("t4_resume_id", int'(bus.res_id), 0);
    chk("t4_resume_s", int'(bus.res_s), 3);

    // Reset while full: slot clears at once, tie priority back to requester 0.
    rst_n = 0;
    #1;
    chk("t5_valid", int'(bus.res_valid), 0);
    chk("t5_s", int'(bus.res_s), 0);
    chk("t5_id", int'(bus.res_id), 0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1;
    cycle();
    chk("t5_first_id", int'(bus.res_id), 0);
    chk("t5_first_valid", int'(bus.res_valid), 1);

    // Drain and accept in the same cycle: no bubble.
    v0 = 0; v1 = 1; x1 = 4'd6; y1 = 4'd9; op1 = 0;
    cycle();
    chk("t6_valid", int'(bus.res_valid), 1);
    chk("t6_id", int'(bus.res_id), 1);
    chk("t6_s", int'(bus.res_s), 4'b1111);
    v1 = 0;

    // Randomized traffic; requesters hold operands until accepted.
    acc0 = 1; acc1 = 1;
    for (int i = 0; i < 400; i++) begin
      if (!(v0 && !acc0)) begin
        v0 = ($urandom_range(0, 3) != 0);
        x0 = N'($urandom); y0 = N'($urandom); op0 = 1'($urandom);
      end
      if (!(v1 && !acc1)) begin
        v1 = ($urandom_range(0, 3) != 0);
        x1 = N'($urandom); y1 = N'($urandom); op1 = 1'($urandom);
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
